// File: rtl/fp_result_packer.sv
// -----------------------------------------------------------------------------
// fp_result_packer
// Final stage of the FP datapath. Accepts an unpacked result (sign, signed
// unbiased exponent, 57-bit mantissa with G/R/S, special flags), normalizes it
// iteratively, rounds to nearest-even and packs an IEEE-754 binary64 word.
// One operation in flight; valid/ready handshake on both sides.
//
// Optional feature macro: FP_PACKER_DENORM_EN
//   defined     : subnormal results are produced by a DENORM right-shift phase
//   not defined : tiny results flush to signed zero (underflow + inexact)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready high only in IDLE)
//   sign_in, exp_in     result sign, signed unbiased exponent (EXP_W bits)
//   mant_in[56:0]       [56:55] int, [54:3] frac, [2] G, [1] R, [0] S
//   is_*_in             special-value flags (priority nan > inf > zero)
//   out_valid/out_ready downstream handshake (out_valid high only in DONE)
//   fp_out              packed binary64
//   flag_*              overflow / underflow / inexact
// -----------------------------------------------------------------------------
module fp_result_packer #(
   parameter int unsigned NORM_STEP = 1,
   parameter int unsigned EXP_W     = 13,
   parameter int unsigned EXP_BIAS  = 1023
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    sign_in,
   input  logic signed [EXP_W-1:0] exp_in,
   input  logic [56:0]             mant_in,
   input  logic                    is_nan_in,
   input  logic                    is_inf_in,
   input  logic                    is_zero_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [63:0]             fp_out,
   output logic                    flag_overflow,
   output logic                    flag_underflow,
   output logic                    flag_inexact
);

   localparam int unsigned EW = EXP_W + 1;
   localparam logic signed [EW-1:0] EOne  = EW'(1);
   localparam logic signed [EW-1:0] EMax  = EW'(2047);
   localparam logic signed [EW-1:0] EBias = EW'(EXP_BIAS);
`ifdef FP_PACKER_DENORM_EN
   localparam logic signed [EW-1:0] EDenMin = EW'(-54);
`endif

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StNorm   = 3'd1,
      StDenorm = 3'd2,
      StRound  = 3'd3,
      StDone   = 3'd4
   } state_e;

   state_e               r_state, w_state_nxt;
   logic                 r_sign, w_sign_nxt;
   logic signed [EW-1:0] r_exp, w_exp_nxt;
   logic [56:0]          r_mant, w_mant_nxt;
   logic [63:0]          r_fp, w_fp_nxt;
   logic                 r_ovf, w_ovf_nxt;
   logic                 r_unf, w_unf_nxt;
   logic                 r_inx, w_inx_nxt;
`ifdef FP_PACKER_DENORM_EN
   logic                 r_tiny, w_tiny_nxt;
`endif

   // Biased exponent of the incoming operand
   logic signed [EW-1:0] w_exp_in;
   assign w_exp_in = $signed({exp_in[EXP_W-1], exp_in}) + EBias;

   // Leading-zero count over the NORM_STEP-bit window below bit 55, capped
   logic [5:0]           w_lz;
   logic signed [EW-1:0] w_lz_e;
   always_comb begin
      w_lz = 6'(NORM_STEP);
      for (int i = int'(NORM_STEP) - 1; i >= 0; i--) begin
         if (r_mant[55 - i]) w_lz = 6'(i);
      end
      w_lz_e = EW'(w_lz);
   end

   // Round-to-nearest-even and pack
   logic                 w_up, w_inx;
   logic [53:0]          w_rnd;
   logic [52:0]          w_sig;
   logic signed [EW-1:0] w_efin;
   logic [63:0]          w_rnd_fp;
   logic                 w_rnd_ovf, w_rnd_unf, w_rnd_inx;
   always_comb begin
      w_up  = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
      w_inx = r_mant[2] | r_mant[1] | r_mant[0];
      w_rnd = r_mant[56:3] + {53'b0, w_up};
      // Carry out of the integer bit renormalizes by one
      if (w_rnd[53]) begin
         w_sig  = w_rnd[53:1];
         w_efin = r_exp + EOne;
      end else begin
         w_sig  = w_rnd[52:0];
         w_efin = r_exp;
      end
      w_rnd_ovf = 1'b0;
      w_rnd_unf = 1'b0;
      w_rnd_inx = w_inx;
      w_rnd_fp  = {r_sign, (w_sig[52] ? w_efin[10:0] : 11'h000), w_sig[51:0]};
      if (w_efin >= EMax) begin
         w_rnd_fp  = {r_sign, 11'h7FF, 52'h0};
         w_rnd_ovf = 1'b1;
         w_rnd_inx = 1'b1;
      end
`ifdef FP_PACKER_DENORM_EN
      else begin
         w_rnd_unf = r_tiny & w_inx;
      end
`else
      else if (w_efin < EOne) begin
         w_rnd_fp  = {r_sign, 63'h0};
         w_rnd_unf = 1'b1;
         w_rnd_inx = 1'b1;
      end
`endif
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_sign_nxt  = r_sign;
      w_exp_nxt   = r_exp;
      w_mant_nxt  = r_mant;
      w_fp_nxt    = r_fp;
      w_ovf_nxt   = r_ovf;
      w_unf_nxt   = r_unf;
      w_inx_nxt   = r_inx;
`ifdef FP_PACKER_DENORM_EN
      w_tiny_nxt  = r_tiny;
`endif
      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_sign_nxt = sign_in;
               w_ovf_nxt  = 1'b0;
               w_unf_nxt  = 1'b0;
               w_inx_nxt  = 1'b0;
`ifdef FP_PACKER_DENORM_EN
               w_tiny_nxt = 1'b0;
`endif
               if (is_nan_in) begin
                  w_fp_nxt    = 64'h7FF8_0000_0000_0000;
                  w_state_nxt = StDone;
               end else if (is_inf_in) begin
                  w_fp_nxt    = {sign_in, 11'h7FF, 52'h0};
                  w_state_nxt = StDone;
               end else if (is_zero_in || (mant_in == '0)) begin
                  w_fp_nxt    = {sign_in, 63'h0};
                  w_state_nxt = StDone;
               end else if (mant_in[56]) begin
                  // Dropped bit is folded into sticky
                  w_mant_nxt  = {1'b0, mant_in[56:2], mant_in[1] | mant_in[0]};
                  w_exp_nxt   = w_exp_in + EOne;
                  w_state_nxt = StNorm;
               end else begin
                  w_mant_nxt  = mant_in;
                  w_exp_nxt   = w_exp_in;
                  w_state_nxt = StNorm;
               end
            end
         end
         StNorm: begin
            if (r_mant[55]) begin
`ifdef FP_PACKER_DENORM_EN
               if (r_exp < EOne) begin
                  w_tiny_nxt  = 1'b1;
                  w_state_nxt = StDenorm;
               end else begin
                  w_state_nxt = StRound;
               end
`else
               w_state_nxt = StRound;
`endif
            end else begin
               w_mant_nxt = r_mant << w_lz;
               w_exp_nxt  = r_exp - w_lz_e;
            end
         end
`ifdef FP_PACKER_DENORM_EN
         StDenorm: begin
            if (r_exp < EDenMin) begin
               // Below half the smallest subnormal: rounds to signed zero
               w_fp_nxt    = {r_sign, 63'h0};
               w_unf_nxt   = 1'b1;
               w_inx_nxt   = 1'b1;
               w_state_nxt = StDone;
            end else if (r_exp == EOne) begin
               w_state_nxt = StRound;
            end else begin
               w_mant_nxt = {1'b0, r_mant[56:2], r_mant[1] | r_mant[0]};
               w_exp_nxt  = r_exp + EOne;
            end
         end
`endif
         StRound: begin
            w_fp_nxt    = w_rnd_fp;
            w_ovf_nxt   = w_rnd_ovf;
            w_unf_nxt   = w_rnd_unf;
            w_inx_nxt   = w_rnd_inx;
            w_state_nxt = StDone;
         end
         StDone: begin
            if (out_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_mant  <= '0;
         r_fp    <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_inx   <= 1'b0;
`ifdef FP_PACKER_DENORM_EN
         r_tiny  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sign  <= w_sign_nxt;
         r_exp   <= w_exp_nxt;
         r_mant  <= w_mant_nxt;
         r_fp    <= w_fp_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
         r_inx   <= w_inx_nxt;
`ifdef FP_PACKER_DENORM_EN
         r_tiny  <= w_tiny_nxt;
`endif
      end
   end

   assign in_ready       = (r_state == StIdle);
   assign out_valid      = (r_state == StDone);
   assign fp_out         = r_fp;
   assign flag_overflow  = r_ovf;
   assign flag_underflow = r_unf;
   assign flag_inexact   = r_inx;

endmodule

// File: tb/tb_fp_result_packer.sv
// -----------------------------------------------------------------------------
// tb_fp_result_packer
// Two instances (NORM_STEP = 1 and 4) share one stimulus stream. Results are
// checked against an exact-arithmetic reference model of binary64 rounding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_result_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n, in_valid, sign_in, is_nan_in, is_inf_in, is_zero_in, out_ready;
   logic signed [12:0] exp_in;
   logic [56:0]        mant_in;
   logic               in_ready1, out_valid1, ovf1, unf1, inx1;
   logic               in_ready4, out_valid4, ovf4, unf4, inx4;
   logic [63:0]        fp1, fp4;

   int n_vec = 0;
   int n_bad = 0;

   fp_result_packer #(.NORM_STEP(1), .EXP_W(13), .EXP_BIAS(1023)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
      .is_nan_in(is_nan_in), .is_inf_in(is_inf_in), .is_zero_in(is_zero_in),
      .out_valid(out_valid1), .out_ready(out_ready), .fp_out(fp1),
      .flag_overflow(ovf1), .flag_underflow(unf1), .flag_inexact(inx1)
   );

   fp_result_packer #(.NORM_STEP(4), .EXP_W(13), .EXP_BIAS(1023)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
      .is_nan_in(is_nan_in), .is_inf_in(is_inf_in), .is_zero_in(is_zero_in),
      .out_valid(out_valid4), .out_ready(out_ready), .fp_out(fp4),
      .flag_overflow(ovf4), .flag_underflow(unf4), .flag_inexact(inx4)
   );

   // Reference: value = m * 2^(e-55), rounded exactly with wide integers.
   // fl = {overflow, underflow, inexact}; lat = cycles from accept to out_valid.
   task automatic model(input logic s, input int e, input logic [56:0] m,
                        input logic nan, input logic inf, input logic zero, input int ns,
                        output logic [63:0] fp, output logic [2:0] fl, output int lat);
      int p, eb, be, j, k, ncyc;
      logic [127:0] mm, q, rem, half;
      logic inx, tiny, up;
      fl  = 3'b000;
      fp  = '0;
      lat = 1;
      if (nan) begin
         fp = 64'h7FF8_0000_0000_0000;
      end else if (inf) begin
         fp = {s, 11'h7FF, 52'h0};
      end else if (zero || m == '0) begin
         fp = {s, 63'h0};
      end else begin
         p = 0;
         for (int i = 0; i < 57; i++) if (m[i]) p = i;
         eb   = e - 55 + p + 1023;
         k    = 55 - ((p > 55) ? 55 : p);
         ncyc = (k + ns - 1) / ns + 1;
         lat  = ncyc + 2;
         tiny = 1'b0;
         j    = p - 52;
`ifdef FP_PACKER_DENORM_EN
         if (eb < 1) begin
            tiny = 1'b1;
            lat  = ncyc + (2 - eb) + 2;
            j    = 55 - 1074 - e;
         end
`endif
         if (tiny && eb < -54) begin
            fp  = {s, 63'h0};
            fl  = 3'b011;
            lat = ncyc + 2;
         end else begin
            mm = 128'(m);
            if (j <= 0) begin
               q   = mm << (-j);
               inx = 1'b0;
            end else begin
               q    = mm >> j;
               rem  = mm & ((128'd1 << j) - 128'd1);
               half = 128'd1 << (j - 1);
               inx  = (rem != 0);
               up   = (rem > half) || (rem == half && q[0]);
               q    = q + 128'(up);
            end
            if (tiny) begin
               fp = {s, q[62:0]};
               fl = {1'b0, inx, inx};
            end else begin
               be = eb;
               if (q == (128'd1 << 53)) begin
                  q  = q >> 1;
                  be = be + 1;
               end
               if (be >= 2047) begin
                  fp = {s, 11'h7FF, 52'h0};
                  fl = 3'b101;
               end else if (be < 1) begin
                  fp = {s, 63'h0};
                  fl = 3'b011;
               end else begin
                  fp = {s, 11'(be), q[51:0]};
                  fl = {2'b00, inx};
               end
            end
         end
      end
   endtask

   // Applies one operation to both instances and collects each result and latency.
   // A latency of -1 means the result never appeared within the cycle budget.
   task automatic drive_op(input logic s, input int e, input logic [56:0] m,
                           input logic nan, input logic inf, input logic zero,
                           output logic [63:0] o_fp1, output logic [2:0] o_fl1, output int o_lat1,
                           output logic [63:0] o_fp4, output logic [2:0] o_fl4, output int o_lat4);
      int cyc;
      bit got1, got4;
      o_fp1 = '0; o_fl1 = '0; o_lat1 = -1;
      o_fp4 = '0; o_fl4 = '0; o_lat4 = -1;
      @(negedge clk);
      cyc = 0;
      while (!(in_ready1 && in_ready4) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      sign_in = s; exp_in = 13'(e); mant_in = m;
      is_nan_in = nan; is_inf_in = inf; is_zero_in = zero;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc  = 1;
      got1 = 1'b0;
      got4 = 1'b0;
      while (!(got1 && got4) && cyc <= 200) begin
         if (!got1 && out_valid1) begin
            o_fp1 = fp1; o_fl1 = {ovf1, unf1, inx1}; o_lat1 = cyc; got1 = 1'b1;
         end
         if (!got4 && out_valid4) begin
            o_fp4 = fp4; o_fl4 = {ovf4, unf4, inx4}; o_lat4 = cyc; got4 = 1'b1;
         end
         if (!(got1 && got4)) begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sign_in = 1'b0; exp_in = '0;
      mant_in = '0; is_nan_in = 1'b0; is_inf_in = 1'b0; is_zero_in = 1'b0;
      #3;
      n_vec++;
      if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0) begin
         n_bad++; $display("FAIL reset out_valid: got %b/%b want 0/0", out_valid1, out_valid4);
      end
      n_vec++;
      if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
         n_bad++; $display("FAIL reset in_ready: got %b/%b want 1/1", in_ready1, in_ready4);
      end
      n_vec++;
      if (fp1 !== 64'h0 || fp4 !== 64'h0) begin
         n_bad++; $display("FAIL reset fp_out: got %h/%h want 0", fp1, fp4);
      end
      n_vec++;
      if ({ovf1, unf1, inx1, ovf4, unf4, inx4} !== 6'b0) begin
         n_bad++; $display("FAIL reset flags: got %b%b%b want 000", ovf1, unf1, inx1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic s; int e; logic [56:0] m; logic nan; logic inf; logic zero;
      logic [63:0] fp; logic [2:0] fl; int lat1; int lat4;
   } vec_t;

   task automatic test_directed();
      vec_t        tbl[15];
      logic [56:0] m55;
      logic [63:0] g_fp1, g_fp4;
      logic [2:0]  g_fl1, g_fl4;
      int          g_lat1, g_lat4;
      m55 = 57'd1 << 55;
      tbl[0]  = '{1'b0, 0, m55, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0000, 3'b000, 3, 3};
      tbl[1]  = '{1'b0, 0, 57'd3 << 55, 1'b0, 1'b0, 1'b0, 64'h4008_0000_0000_0000, 3'b000, 3, 3};
      tbl[2]  = '{1'b0, 0, m55 | 57'd4, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0000, 3'b001, 3, 3};
      tbl[3]  = '{1'b0, 0, m55 | 57'd12, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0002, 3'b001, 3, 3};
      tbl[4]  = '{1'b0, 0, 57'd1 << 45, 1'b0, 1'b0, 1'b0, 64'h3F50_0000_0000_0000, 3'b000, 13, 6};
      tbl[5]  = '{1'b0, 1024, m55, 1'b0, 1'b0, 1'b0, 64'h7FF0_0000_0000_0000, 3'b101, 3, 3};
`ifdef FP_PACKER_DENORM_EN
      tbl[6]  = '{1'b0, -1023, m55, 1'b0, 1'b0, 1'b0, 64'h0008_0000_0000_0000, 3'b000, 5, 5};
`else
      tbl[6]  = '{1'b0, -1023, m55, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 3'b011, 3, 3};
`endif
      tbl[7]  = '{1'b1, 0, m55, 1'b1, 1'b0, 1'b0, 64'h7FF8_0000_0000_0000, 3'b000, 1, 1};
      tbl[8]  = '{1'b1, 0, m55, 1'b0, 1'b1, 1'b0, 64'hFFF0_0000_0000_0000, 3'b000, 1, 1};
      tbl[9]  = '{1'b1, 0, m55, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 3'b000, 1, 1};
      tbl[10] = '{1'b0, 5, 57'd0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 3'b000, 1, 1};
      tbl[11] = '{1'b0, 0, m55, 1'b1, 1'b1, 1'b1, 64'h7FF8_0000_0000_0000, 3'b000, 1, 1};
      tbl[12] = '{1'b0, 0, {57{1'b1}}, 1'b0, 1'b0, 1'b0, 64'h4010_0000_0000_0000, 3'b001, 3, 3};
      tbl[13] = '{1'b1, -1, 57'd3 << 54, 1'b0, 1'b0, 1'b0, 64'hBFE8_0000_0000_0000, 3'b000, 3, 3};
      tbl[14] = '{1'b0, 0, m55 | 57'd5, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0001, 3'b001, 3, 3};
      foreach (tbl[i]) begin
         drive_op(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].nan, tbl[i].inf, tbl[i].zero,
                  g_fp1, g_fl1, g_lat1, g_fp4, g_fl4, g_lat4);
         n_vec++;
         if (g_fp1 !== tbl[i].fp) begin
            n_bad++; $display("FAIL dir%0d fp ns1: got %h want %h", i, g_fp1, tbl[i].fp);
         end
         n_vec++;
         if (g_fp4 !== tbl[i].fp) begin
            n_bad++; $display("FAIL dir%0d fp ns4: got %h want %h", i, g_fp4, tbl[i].fp);
         end
         n_vec++;
         if (g_fl1 !== tbl[i].fl || g_fl4 !== tbl[i].fl) begin
            n_bad++;
            $display("FAIL dir%0d flags: got %b/%b want %b", i, g_fl1, g_fl4, tbl[i].fl);
         end
         n_vec++;
         if (g_lat1 != tbl[i].lat1) begin
            n_bad++; $display("FAIL dir%0d latency ns1: got %0d want %0d", i, g_lat1, tbl[i].lat1);
         end
         n_vec++;
         if (g_lat4 != tbl[i].lat4) begin
            n_bad++; $display("FAIL dir%0d latency ns4: got %0d want %0d", i, g_lat4, tbl[i].lat4);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] rr, e_fp1, e_fp4, g_fp1, g_fp4;
      logic [2:0]  e_fl1, e_fl4, g_fl1, g_fl4;
      int          e_lat1, e_lat4, g_lat1, g_lat4, e, cls, sp;
      logic [56:0] m;
      logic        s, nan, inf, zero;
      for (int n = 0; n < 60; n++) begin
         rr  = {$urandom(), $urandom()};
         m   = rr[56:0] >> $urandom_range(0, 56);
         s   = 1'(($urandom() & 1));
         cls = int'($urandom_range(0, 2));
         if (cls == 0)      e = int'($urandom_range(0, 120)) - 60;
         else if (cls == 1) e = int'($urandom_range(0, 80)) + 1000;
         else               e = -int'($urandom_range(960, 1110));
         sp   = int'($urandom_range(0, 15));
         nan  = (sp == 0);
         inf  = (sp == 0) || (sp == 1);
         zero = (sp <= 2);
         model(s, e, m, nan, inf, zero, 1, e_fp1, e_fl1, e_lat1);
         model(s, e, m, nan, inf, zero, 4, e_fp4, e_fl4, e_lat4);
         drive_op(s, e, m, nan, inf, zero, g_fp1, g_fl1, g_lat1, g_fp4, g_fl4, g_lat4);
         n_vec++;
         if (g_fp1 !== e_fp1 || g_fl1 !== e_fl1) begin
            n_bad++;
            $display("FAIL rnd%0d ns1 e=%0d m=%h: got %h/%b want %h/%b",
                     n, e, m, g_fp1, g_fl1, e_fp1, e_fl1);
         end
         n_vec++;
         if (g_fp4 !== e_fp4 || g_fl4 !== e_fl4) begin
            n_bad++;
            $display("FAIL rnd%0d ns4 e=%0d m=%h: got %h/%b want %h/%b",
                     n, e, m, g_fp4, g_fl4, e_fp4, e_fl4);
         end
         n_vec++;
         if (g_lat1 != e_lat1 || g_lat4 != e_lat4) begin
            n_bad++;
            $display("FAIL rnd%0d latency: got %0d/%0d want %0d/%0d",
                     n, g_lat1, g_lat4, e_lat1, e_lat4);
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      @(negedge clk);
      cyc = 0;
      while (!(in_ready1 && in_ready4) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      sign_in = 1'b1; exp_in = '0; mant_in = 57'd1 << 55;
      is_nan_in = 1'b1; is_inf_in = 1'b0; is_zero_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      is_nan_in = 1'b0;
      n_vec++;
      if (out_valid1 !== 1'b1 || fp1 !== 64'h7FF8_0000_0000_0000) begin
         n_bad++; $display("FAIL nan latency1: got v=%b %h want v=1 7ff8000000000000", out_valid1, fp1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || fp1 !== 64'h7FF8_0000_0000_0000 ||
             fp4 !== 64'h7FF8_0000_0000_0000 || in_ready4 !== 1'b0) begin
            n_bad++;
            $display("FAIL hold%0d: got v=%b rdy=%b %h/%h want v=1 rdy=0 7ff8000000000000",
                     i, out_valid1, in_ready1, fp1, fp4);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
         n_bad++; $display("FAIL release: got v=%b rdy=%b want v=0 rdy=1", out_valid1, in_ready1);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] g_fp1, g_fp4;
      logic [2:0]  g_fl1, g_fl4;
      int          g_lat1, g_lat4;
      @(negedge clk);
      sign_in = 1'b0; exp_in = '0; mant_in = 57'd1 << 45;
      is_nan_in = 1'b0; is_inf_in = 1'b0; is_zero_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (in_ready1 !== 1'b0) begin
         n_bad++; $display("FAIL busy before reset: got rdy=%b want 0", in_ready1);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0 || in_ready1 !== 1'b1 ||
          in_ready4 !== 1'b1 || fp1 !== 64'h0) begin
         n_bad++;
         $display("FAIL mid-op reset: got v=%b/%b rdy=%b/%b fp=%h want v=0 rdy=1 fp=0",
                  out_valid1, out_valid4, in_ready1, in_ready4, fp1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(1'b0, 0, 57'd1 << 55, 1'b0, 1'b0, 1'b0, g_fp1, g_fl1, g_lat1, g_fp4, g_fl4, g_lat4);
      n_vec++;
      if (g_fp1 !== 64'h3FF0_0000_0000_0000 || g_lat1 != 3 || g_fl1 !== 3'b000) begin
         n_bad++;
         $display("FAIL after reset: got %h lat %0d fl %b want 3ff0000000000000 lat 3 fl 000",
                  g_fp1, g_lat1, g_fl1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
